// File: rtl/mux16_rr_scheduler.sv
// mux16_rr_scheduler: round-robin owner of the select line of a shared 16:1 bit mux.
// The 4-bit select and the one-hot grant stay stable for the whole grant.
// The multiplexed bit is registered as dout, one cycle behind sel.
// Optional feature: define MUX16_SCHED_TIMEOUT_EN to force rotation after
// MAX_HOLD cycles of holding; timeout then pulses for one cycle.
// Without the macro no hold counter exists and timeout is tied low.
module mux16_rr_scheduler #(
    parameter int SEL_W    = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [(1<<SEL_W)-1:0]   req,
    input  logic                    done,
    input  logic [(1<<SEL_W)-1:0]   din,
    output logic [SEL_W-1:0]        sel,
    output logic [(1<<SEL_W)-1:0]   gnt,
    output logic                    gnt_vld,
    output logic                    dout,
    output logic                    dout_vld,
    output logic                    timeout
);

    localparam int N = 1 << SEL_W;
    localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t             state_q;
    logic [SEL_W-1:0]   sel_q;
    logic [SEL_W-1:0]   last_q;
    logic [N-1:0]       gnt_q;
    logic               gnt_vld_q;
    logic               dout_q;
    logic               dout_vld_q;

    logic [SEL_W:0]     pick_s;
    logic               found_s;
    logic [SEL_W-1:0]   winner_s;
    logic               hold_hit_s;
    logic               user_rel_s;
    logic               release_s;
    logic               forced_s;
    logic               new_grant_s;

    // Rotating priority scan: last+1 first, last itself is lowest priority.
    function automatic logic [SEL_W:0] rr_pick(input logic [N-1:0] r,
                                               input logic [SEL_W-1:0] last);
        logic [SEL_W-1:0] cand;
        logic             found;
        logic [SEL_W-1:0] win;
        found = 1'b0;
        win   = last;
        for (int i = 1; i <= N; i++) begin
            cand = last + i[SEL_W-1:0];
            if (!found && r[cand]) begin
                found = 1'b1;
                win   = cand;
            end else begin
                found = found;
            end
        end
        return {found, win};
    endfunction

    assign pick_s   = rr_pick(req, last_q);
    assign found_s  = pick_s[SEL_W];
    assign winner_s = pick_s[SEL_W-1:0];

`ifdef MUX16_SCHED_TIMEOUT_EN
    logic [7:0] hold_q;
    logic       timeout_q;

    assign hold_hit_s = (hold_q == 8'(MAX_HOLD - 1));
`else
    assign hold_hit_s = 1'b0;
`endif

    // Release decode: done or a dropped request win over a forced rotation.
    always_comb begin
        user_rel_s  = done | ~req[sel_q];
        release_s   = 1'b0;
        forced_s    = 1'b0;
        new_grant_s = 1'b0;
        if (state_q == ST_GRANT) begin
            release_s   = user_rel_s | hold_hit_s;
            forced_s    = hold_hit_s & ~user_rel_s;
            new_grant_s = (user_rel_s | hold_hit_s) & found_s;
        end else begin
            new_grant_s = found_s;
        end
    end

    // Grant FSM: owns state, select, grant vector and the last-grant pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            sel_q     <= {SEL_W{1'b0}};
            last_q    <= {SEL_W{1'b1}};
            gnt_q     <= {N{1'b0}};
            gnt_vld_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_GRANT: begin
                    if (new_grant_s) begin
                        state_q   <= ST_GRANT;
                        sel_q     <= winner_s;
                        last_q    <= winner_s;
                        gnt_q     <= ONE_N << winner_s;
                        gnt_vld_q <= 1'b1;
                    end else if (state_q == ST_IDLE || release_s) begin
                        state_q   <= ST_IDLE;
                        gnt_q     <= {N{1'b0}};
                        gnt_vld_q <= 1'b0;
                    end else begin
                        state_q   <= ST_GRANT;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    gnt_q     <= {N{1'b0}};
                    gnt_vld_q <= 1'b0;
                end
            endcase
        end
    end

    // Data path: sample the muxed bit while a grant is active.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q     <= 1'b0;
            dout_vld_q <= 1'b0;
        end else if (gnt_vld_q) begin
            dout_q     <= din[sel_q];
            dout_vld_q <= 1'b1;
        end else begin
            dout_vld_q <= 1'b0;
        end
    end

`ifdef MUX16_SCHED_TIMEOUT_EN
    // Hold counter and timeout pulse: restart on each grant, count while holding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q    <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= forced_s;
            if (new_grant_s) begin
                hold_q <= 8'd0;
            end else if (state_q == ST_GRANT) begin
                hold_q <= hold_q + 8'd1;
            end else begin
                hold_q <= 8'd0;
            end
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign sel      = sel_q;
    assign gnt      = gnt_q;
    assign gnt_vld  = gnt_vld_q;
    assign dout     = dout_q;
    assign dout_vld = dout_vld_q;

endmodule

// File: tb/tb_mux16_rr_scheduler.sv
// Self-checking bench for mux16_rr_scheduler: directed scenarios plus random
// traffic compared against an integer-level round-robin reference model.
module tb_mux16_rr_scheduler;

`ifdef MUX16_SCHED_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int MAX_HOLD = 8;

    logic        clk;
    logic        rst_n;
    logic [15:0] req;
    logic        done;
    logic [15:0] din;
    logic [3:0]  sel;
    logic [15:0] gnt;
    logic        gnt_vld;
    logic        dout;
    logic        dout_vld;
    logic        timeout;

    int err_cnt = 0;
    int chk_cnt = 0;

    // reference model state (plain integers)
    int       m_busy, m_sel, m_last, m_hold;
    bit       m_dout, m_dvld, m_to;

    mux16_rr_scheduler #(.SEL_W(4), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done), .din(din),
        .sel(sel), .gnt(gnt), .gnt_vld(gnt_vld), .dout(dout),
        .dout_vld(dout_vld), .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_sel = 0; m_last = 15; m_hold = 0;
        m_dout = 1'b0; m_dvld = 1'b0; m_to = 1'b0;
    endtask

    // One clock edge of the scheduler, as described by its rules.
    task automatic model_step(input logic [15:0] r, input bit d, input logic [15:0] di);
        bit rel, forced;
        int winner;
        if (m_busy != 0) begin
            m_dout = di[m_sel];
            m_dvld = 1'b1;
        end else begin
            m_dvld = 1'b0;
        end
        rel = 1'b0; forced = 1'b0; m_to = 1'b0;
        if (m_busy == 0) rel = 1'b1;
        else if (d || !r[m_sel]) rel = 1'b1;
        else if (TO_EN && m_hold == MAX_HOLD - 1) begin rel = 1'b1; forced = 1'b1; end
        if (rel) begin
            winner = -1;
            for (int k = 1; k <= 16; k++)
                if (winner < 0 && r[(m_last + k) % 16]) winner = (m_last + k) % 16;
            if (winner >= 0) begin
                m_sel = winner; m_last = winner; m_busy = 1; m_hold = 0;
                m_to = forced;
            end else begin
                m_busy = 0;
            end
        end else begin
            m_hold = m_hold + 1;
        end
    endtask

    task automatic compare_all();
        logic [15:0] eg;
        eg = (m_busy != 0) ? (16'h0001 << m_sel) : 16'h0000;
        check_eq("sel",      32'(sel),      32'(m_sel));
        check_eq("gnt",      32'(gnt),      32'(eg));
        check_eq("gnt_vld",  32'(gnt_vld),  32'(m_busy != 0));
        check_eq("dout",     32'(dout),     32'(m_dout));
        check_eq("dout_vld", 32'(dout_vld), 32'(m_dvld));
        check_eq("timeout",  32'(timeout),  32'(m_to));
    endtask

    task automatic cycle(input logic [15:0] r, input logic d, input logic [15:0] di);
        req = r; done = d; din = di;
        @(posedge clk);
        model_step(r, d, di);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("rst_sel",      32'(sel),      32'd0);
        check_eq("rst_gnt",      32'(gnt),      32'd0);
        check_eq("rst_gnt_vld",  32'(gnt_vld),  32'd0);
        check_eq("rst_dout",     32'(dout),     32'd0);
        check_eq("rst_dout_vld", 32'(dout_vld), 32'd0);
        check_eq("rst_timeout",  32'(timeout),  32'd0);
        req = 16'h0000; done = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int exp_rot [5] = '{0, 5, 10, 15, 0};

    initial begin
        rst_n = 1'b1; req = 16'h0000; done = 1'b0; din = 16'h0000;
        model_reset();
        do_reset();

        // mid-grant async reset on sel=5, then fresh grant on 0
        cycle(16'h0020, 1'b0, 16'h0000);
        cycle(16'h0020, 1'b0, 16'h0000);
        check_eq("pre_rst_sel", 32'(sel), 32'd5);
        do_reset();
        cycle(16'h0001, 1'b0, 16'h0000);
        check_eq("post_rst_sel", 32'(sel), 32'd0);
        check_eq("post_rst_vld", 32'(gnt_vld), 32'd1);

        // single grant and data
        do_reset();
        cycle(16'h0001, 1'b0, 16'h3f0a);
        check_eq("single_gnt", 32'(gnt), 32'h0001);
        cycle(16'h0001, 1'b0, 16'h3f0a);
        check_eq("single_dout_vld", 32'(dout_vld), 32'd1);
        cycle(16'h0001, 1'b1, 16'h3f0a);
        check_eq("regrant_sel", 32'(sel), 32'd0);

        // rotation with wrap
        do_reset();
        for (int c = 0; c < 10; c++) begin
            cycle(16'h8421, (c % 2 == 0), 16'hA5C3);
            if (c % 2 == 0) check_eq("rot_sel", 32'(sel), 32'(exp_rot[c / 2]));
            check_eq("rot_vld", 32'(gnt_vld), 32'd1);
        end

        // drop release, then done in IDLE
        do_reset();
        cycle(16'h0004, 1'b0, 16'h0004);
        check_eq("drop_sel", 32'(sel), 32'd2);
        cycle(16'h0000, 1'b0, 16'h0004);
        check_eq("drop_vld", 32'(gnt_vld), 32'd0);
        cycle(16'h0000, 1'b1, 16'h0004);
        check_eq("idle_done_gnt", 32'(gnt), 32'd0);

        // timeout scenario: 16 cycles without done, then done
        do_reset();
        for (int c = 1; c <= 17; c++) begin
            cycle(16'h0003, (c == 17), 16'h0002);
            if (TO_EN && c == 9) begin
                check_eq("to_rot_sel", 32'(sel), 32'd1);
                check_eq("to_pulse", 32'(timeout), 32'd1);
            end
            if (TO_EN && c == 17) begin
                check_eq("to_coinc_sel", 32'(sel), 32'd0);
                check_eq("to_coinc_pulse", 32'(timeout), 32'd0);
            end
            if (!TO_EN && c == 16) check_eq("noto_sel", 32'(sel), 32'd0);
        end
        for (int c = 0; c < 55; c++) cycle(16'h0003, 1'b0, 16'h0002);
        if (!TO_EN) check_eq("noto_hold_sel", 32'(sel), 32'd1);

        // random traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            logic [15:0] r;
            r = 16'($urandom) & 16'($urandom) & 16'($urandom);
            if ($urandom_range(0, 7) == 0) r = 16'h0000;
            if (c % 500 == 250) do_reset();
            cycle(r, ($urandom_range(0, 3) == 0), 16'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
